// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word type plus the instruction-cache frame layout and FSM states.
// Tag/index widths below describe the default 16-frame geometry.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   localparam int IIDX_W = 4;
   localparam int ITAG_W = 32 - IIDX_W - 2;

   typedef struct packed {
      logic              valid;
      logic [ITAG_W-1:0] tag;
      word_t             data;
   } icache_frame_t;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } icache_state_t;

endpackage

// File: rtl/icache_responder.sv
// Direct-mapped blocking instruction cache: zero-cycle hits, single-word refill from the
// memory controller over iREN/iwait, with a one-pulse global invalidate.
module icache_responder
   import cpu_types_pkg::*;
#(
   parameter int SETS = 16
) (
   input  logic  CLK,
   input  logic  RST,
   input  logic  imemREN,
   input  word_t imemaddr,
   input  logic  iflush,
   output logic  ihit,
   output word_t imemload,
   output logic  iREN,
   output word_t iaddr,
   input  logic  iwait,
   input  word_t iload
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 30 - IDX_W;

   icache_state_t     state_reg, state_next;
   word_t             miss_addr_reg, miss_addr_next;

   logic [SETS-1:0]   valid_reg;
   logic [TAG_W-1:0]  tag_mem [SETS];
   word_t             data_mem [SETS];

   logic [IDX_W-1:0]  req_idx, fill_idx;
   logic [TAG_W-1:0]  req_tag, fill_tag;
   logic              hit;
   logic              fill;

   // Byte offset is irrelevant for word fetches.
   logic unused_offset;
   assign unused_offset = ^{imemaddr[1:0], miss_addr_reg[1:0]};

   assign req_idx  = imemaddr[IDX_W+1:2];
   assign req_tag  = imemaddr[31:IDX_W+2];
   assign fill_idx = miss_addr_reg[IDX_W+1:2];
   assign fill_tag = miss_addr_reg[31:IDX_W+2];

   assign hit  = imemREN & valid_reg[req_idx] & (tag_mem[req_idx] == req_tag);
   assign fill = (state_reg == FETCH) & ~iwait & ~iflush;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg     <= IDLE;
         miss_addr_reg <= '0;
      end else begin
         state_reg     <= state_next;
         miss_addr_reg <= miss_addr_next;
      end
   end

   // Flush beats a same-edge fill, so a frame is never marked valid across an invalidate.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         valid_reg <= '0;
      end else if (iflush) begin
         valid_reg <= '0;
      end else if (fill) begin
         valid_reg[fill_idx] <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (fill) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= iload;
      end
   end

   always_comb begin
      state_next     = state_reg;
      miss_addr_next = miss_addr_reg;
      ihit           = 1'b0;
      imemload       = '0;
      iREN           = 1'b0;
      iaddr          = '0;
      case (state_reg)
         IDLE: begin
            ihit = hit;
            if (hit) begin
               imemload = data_mem[req_idx];
            end else if (imemREN) begin
               miss_addr_next = {imemaddr[31:2], 2'b00};
               state_next     = FETCH;
            end
         end
         FETCH: begin
            iREN  = 1'b1;
            iaddr = miss_addr_reg;
            if (iflush || !iwait) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: a per-cycle vector table followed by reset sequences.
module tb_icache_responder;
   import cpu_types_pkg::*;

   logic  CLK = 1'b0;
   logic  RST;
   logic  imemREN;
   word_t imemaddr;
   logic  iflush;
   logic  ihit;
   word_t imemload;
   logic  iREN;
   word_t iaddr;
   logic  iwait;
   word_t iload;

   int n_checks = 0;
   int n_fail   = 0;

   icache_responder #(.SETS(16)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .imemREN  (imemREN),
      .imemaddr (imemaddr),
      .iflush   (iflush),
      .ihit     (ihit),
      .imemload (imemload),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic  ren;
      word_t addr;
      logic  flush;
      logic  wt;
      word_t load;
      logic  e_hit;
      word_t e_data;
      logic  e_ren;
      word_t e_iaddr;
   } vec_t;

   localparam int NV = 30;
   vec_t vec [NV];

   task automatic check(input string name, input word_t act, input word_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic e_hit, input word_t e_data,
                            input logic e_ren, input word_t e_iaddr);
      check({tag, " ihit"},     {31'b0, ihit}, {31'b0, e_hit});
      check({tag, " imemload"}, imemload,      e_data);
      check({tag, " iREN"},     {31'b0, iREN}, {31'b0, e_ren});
      check({tag, " iaddr"},    iaddr,         e_iaddr);
   endtask

   task automatic drive(input logic ren, input word_t addr, input logic flush,
                        input logic wt, input word_t load);
      imemREN  = ren;
      imemaddr = addr;
      iflush   = flush;
      iwait    = wt;
      iload    = load;
   endtask

   initial begin
      //            ren  addr          fl  wt  load          hit  data          iREN iaddr
      vec[0]  = '{1'b1, 32'h0000_0004, 1'b0, 1'b1, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0};
      vec[1]  = '{1'b1, 32'h0000_0004, 1'b0, 1'b1, 32'h0,          1'b0, 32'h0,          1'b1, 32'h4};
      vec[2]  = '{1'b1, 32'h0000_0004, 1'b0, 1'b1, 32'h0,          1'b0, 32'h0,          1'b1, 32'h4};
      vec[3]  = '{1'b1, 32'h0000_0004, 1'b0, 1'b1, 32'h0,          1'b0, 32'h0,          1'b1, 32'h4};
      vec[4]  = '{1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'hDEAD_BEEF,  1'b0, 32'h0,          1'b1, 32'h4};
      vec[5]  = '{1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'h0,          1'b1, 32'hDEAD_BEEF,  1'b0, 32'h0};
      vec[6]  = '{1'b1, 32'h0000_0006, 1'b0, 1'b0, 32'h0,          1'b1, 32'hDEAD_BEEF,  1'b0, 32'h0};
      vec[7]  = '{1'b0, 32'h0000_0004, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0};
      vec[8]  = '{1'b1, 32'h0000_0044, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0};
      vec[9]  = '{1'b1, 32'h0000_0044, 1'b0, 1'b0, 32'h1111_1111,  1'b0, 32'h0,          1'b1, 32'h44};
      vec[10] = '{1'b1, 32'h0000_0044, 1'b0, 1'b0, 32'h0,          1'b1, 32'h1111_1111,  1'b0, 32'h0};
      vec[11] = '{1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0};
      vec[12] = '{1'b0, 32'h0000_0080, 1'b0, 1'b0, 32'hCAFE_F00D,  1'b0, 32'h0,          1'b1, 32'h4};
      vec[13] = '{1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'h0,          1'b1, 32'hCAFE_F00D,  1'b0, 32'h0};
      vec[14] = '{1'b1, 32'h0000_0044, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0};
      vec[15] = '{1'b1, 32'h0000_0044, 1'b0, 1'b0, 32'h2222_2222,  1'b0, 32'h0,          1'b1, 32'h44};
      vec[16] = '{1'b1, 32'h0000_0044, 1'b0, 1'b0, 32'h0,          1'b1, 32'h2222_2222,  1'b0, 32'h0};
      vec[17] = '{1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0};
      vec[18] = '{1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'h3333_3333,  1'b0, 32'h0,          1'b1, 32'h8};
      vec[19] = '{1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'h0,          1'b1, 32'h3333_3333,  1'b0, 32'h0};
      vec[20] = '{1'b0, 32'h0000_0008, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0};
      vec[21] = '{1'b1, 32'h0000_0008, 1'b0, 1'b1, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0};
      vec[22] = '{1'b1, 32'h0000_0008, 1'b1, 1'b1, 32'h0,          1'b0, 32'h0,          1'b1, 32'h8};
      vec[23] = '{1'b0, 32'h0000_0008, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0};
      vec[24] = '{1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0};
      vec[25] = '{1'b1, 32'h0000_0008, 1'b1, 1'b0, 32'h4444_4444,  1'b0, 32'h0,          1'b1, 32'h8};
      vec[26] = '{1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0};
      vec[27] = '{1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'h5555_5555,  1'b0, 32'h0,          1'b1, 32'h8};
      vec[28] = '{1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'h0,          1'b1, 32'h5555_5555,  1'b0, 32'h0};
      vec[29] = '{1'b1, 32'h0000_0044, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0};

      RST = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check_all("reset", 1'b0, 32'h0, 1'b0, 32'h0);
      $display("reset state checked");
      @(posedge CLK);
      #1 RST = 1'b0;

      for (int i = 0; i < NV; i++) begin
         drive(vec[i].ren, vec[i].addr, vec[i].flush, vec[i].wt, vec[i].load);
         @(negedge CLK);
         check_all($sformatf("vec%0d", i), vec[i].e_hit, vec[i].e_data, vec[i].e_ren,
                   vec[i].e_iaddr);
         $display("vec%0d ren=%0b addr=0x%08h flush=%0b iwait=%0b -> ihit=%0b imemload=0x%08h iREN=%0b iaddr=0x%08h",
                  i, imemREN, imemaddr, iflush, iwait, ihit, imemload, iREN, iaddr);
         @(posedge CLK);
         #1;
      end

      // vec29 left the FSM in FETCH for 0x44 with iwait=0; finish it so index 1 holds 0x44.
      drive(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0);
      @(posedge CLK);
      #1;

      // Reset in the middle of a fetch held off by iwait.
      drive(1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'h0);
      @(negedge CLK);
      check_all("rst_pre_miss", 1'b0, 32'h0, 1'b0, 32'h0);
      @(posedge CLK);
      #1;
      check_all("rst_fetch", 1'b0, 32'h0, 1'b1, 32'h40);
      #2 RST = 1'b1;
      #1;
      check_all("rst_async", 1'b0, 32'h0, 1'b0, 32'h0);
      $display("async reset mid-FETCH: iREN=%0b iaddr=0x%08h", iREN, iaddr);
      @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      check_all("rst_miss40", 1'b0, 32'h0, 1'b0, 32'h0);
      @(posedge CLK);
      #1;
      drive(1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h6666_6666);
      @(negedge CLK);
      check_all("rst_refetch40", 1'b0, 32'h0, 1'b1, 32'h40);
      @(posedge CLK);
      #1;
      drive(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0);
      @(negedge CLK);
      check_all("rst_hit40", 1'b1, 32'h6666_6666, 1'b0, 32'h0);
      $display("post-reset 0x40 fill: ihit=%0b imemload=0x%08h", ihit, imemload);
      @(posedge CLK);
      #1;
      drive(1'b1, 32'h0000_0008, 1'b0, 1'b1, 32'h0);
      @(negedge CLK);
      check_all("rst_cleared8", 1'b0, 32'h0, 1'b0, 32'h0);
      $display("post-reset 0x8 lookup: ihit=%0b", ihit);
      @(posedge CLK);
      #1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      @(posedge CLK);
      #1;
      @(negedge CLK);
      check_all("final_idle", 1'b0, 32'h0, 1'b0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
